btn_debounce: RTL and testbench

Upstream conditioning stage for the ZedBoard push-button/switch bank. It synchronises eight asynchronous raw inputs to the system clock and debounces each bit independently with a stability counter. It produces clean levels, single-cycle rise/fall pulses and a per-bit toggle register. Its `Btn` output is the clean 8-bit bus consumed by `SWLed` and any other button-driven logic.

---
 rtl/btn_debounce.sv | 107 ++++++++++
 tb/tb_btn_debounce.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/btn_debounce.sv
// Button/switch conditioning: two-flop synchroniser plus per-bit stability
// counter, giving clean levels, one-cycle edge pulses and a toggle register.

module btn_debounce_lane #(
  parameter int STABLE_CYCLES = 1_000_000,
  parameter int CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
  input  logic Clk,
  input  logic Rst_n,
  input  logic raw,
  output logic btn,
  output logic rise,
  output logic fall,
  output logic toggle
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             btn_q, btn_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             toggle_q, toggle_d;

  always_comb begin
    sync1_d  = raw;
    sync2_d  = sync1_q;
    cnt_d    = cnt_q;
    btn_d    = btn_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    toggle_d = toggle_q;
    // Any agreement with the current level restarts the stability window.
    if (sync2_q == btn_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d    = '0;
      btn_d    = sync2_q;
      rise_d   = sync2_q;
      fall_d   = ~sync2_q;
      toggle_d = toggle_q ^ sync2_q;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      cnt_q    <= '0;
      btn_q    <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      toggle_q <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      cnt_q    <= cnt_d;
      btn_q    <= btn_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      toggle_q <= toggle_d;
    end
  end

  assign btn    = btn_q;
  assign rise   = rise_q;
  assign fall   = fall_q;
  assign toggle = toggle_q;

endmodule

module btn_debounce #(
  parameter int N             = 8,
  parameter int STABLE_CYCLES = 1_000_000,
  parameter int CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
  input  logic         Clk,
  input  logic         Rst_n,
  input  logic [N-1:0] BtnRaw,
  output logic [N-1:0] Btn,
  output logic [N-1:0] BtnRise,
  output logic [N-1:0] BtnFall,
  output logic [N-1:0] Toggle
);

  // Bits share nothing, so simultaneous presses pulse together.
  for (genvar i = 0; i < N; i++) begin : g_lane
    btn_debounce_lane #(
      .STABLE_CYCLES(STABLE_CYCLES),
      .CNT_W        (CNT_W)
    ) u_lane (
      .Clk   (Clk),
      .Rst_n (Rst_n),
      .raw   (BtnRaw[i]),
      .btn   (Btn[i]),
      .rise  (BtnRise[i]),
      .fall  (BtnFall[i]),
      .toggle(Toggle[i])
    );
  end

endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce with STABLE_CYCLES=4, N=8.

module tb_btn_debounce;

  logic       Clk = 1'b0;
  logic       Rst_n;
  logic [7:0] BtnRaw;
  logic [7:0] Btn, BtnRise, BtnFall, Toggle;

  int ncmp = 0;
  int nerr = 0;

  btn_debounce #(.N(8), .STABLE_CYCLES(4)) dut (
    .Clk    (Clk),
    .Rst_n  (Rst_n),
    .BtnRaw (BtnRaw),
    .Btn    (Btn),
    .BtnRise(BtnRise),
    .BtnFall(BtnFall),
    .Toggle (Toggle)
  );

  always #5 Clk = ~Clk;

  task automatic tick(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    Rst_n  = 1'b0;
    BtnRaw = 8'h00;
    tick(2);
    chk("rst_btn", Btn, 8'h00);
    chk("rst_rise", BtnRise, 8'h00);
    chk("rst_fall", BtnFall, 8'h00);
    chk("rst_tog", Toggle, 8'h00);
    Rst_n = 1'b1;
    tick(1);

    // Clean press then release on bit 0
    BtnRaw = 8'h01;
    tick(5);
    chk("press_early_btn", Btn, 8'h00);
    chk("press_early_rise", BtnRise, 8'h00);
    tick(1);
    chk("press_btn", Btn, 8'h01);
    chk("press_rise", BtnRise, 8'h01);
    chk("press_tog", Toggle, 8'h01);
    tick(1);
    chk("press_rise_end", BtnRise, 8'h00);
    chk("press_hold_btn", Btn, 8'h01);
    BtnRaw = 8'h00;
    tick(5);
    chk("rel_early_btn", Btn, 8'h01);
    chk("rel_early_fall", BtnFall, 8'h00);
    tick(1);
    chk("rel_btn", Btn, 8'h00);
    chk("rel_fall", BtnFall, 8'h01);
    chk("rel_tog", Toggle, 8'h01);
    tick(1);
    chk("rel_fall_end", BtnFall, 8'h00);

    // 3-cycle glitch on bit 3 must be rejected
    BtnRaw = 8'h08;
    tick(3);
    BtnRaw = 8'h00;
    for (int c = 0; c < 8; c++) begin
      tick(1);
      chk("glitch_btn", Btn, 8'h00);
      chk("glitch_rise", BtnRise, 8'h00);
      chk("glitch_tog", Toggle, 8'h01);
    end
    // 4-cycle pulse is just long enough
    BtnRaw = 8'h08;
    tick(4);
    BtnRaw = 8'h00;
    tick(1);
    chk("pulse4_early_btn", Btn, 8'h00);
    tick(1);
    chk("pulse4_btn", Btn, 8'h08);
    chk("pulse4_rise", BtnRise, 8'h08);
    chk("pulse4_tog", Toggle, 8'h09);
    tick(8);
    chk("pulse4_rel_btn", Btn, 8'h00);
    chk("pulse4_rel_tog", Toggle, 8'h09);

    // Bounce on bit 5: 1,0,1,1,0 then hold 1
    BtnRaw = 8'h20; tick(1);
    BtnRaw = 8'h00; tick(1);
    BtnRaw = 8'h20; tick(1);
    BtnRaw = 8'h20; tick(1);
    BtnRaw = 8'h00; tick(1);
    chk("bounce_mid_btn", Btn, 8'h00);
    BtnRaw = 8'h20;
    for (int c = 0; c < 5; c++) begin
      tick(1);
      chk("bounce_wait_btn", Btn, 8'h00);
      chk("bounce_wait_rise", BtnRise, 8'h00);
    end
    tick(1);
    chk("bounce_btn", Btn, 8'h20);
    chk("bounce_rise", BtnRise, 8'h20);
    chk("bounce_tog", Toggle, 8'h29);

    // Reset in the middle of a pulse cycle clears everything at once
    Rst_n = 1'b0;
    #2;
    chk("rstpulse_btn", Btn, 8'h00);
    chk("rstpulse_rise", BtnRise, 8'h00);
    chk("rstpulse_fall", BtnFall, 8'h00);
    chk("rstpulse_tog", Toggle, 8'h00);
    BtnRaw = 8'h00;
    tick(2);
    Rst_n = 1'b1;
    tick(2);

    // Simultaneous multi-bit press
    BtnRaw = 8'hA5;
    tick(5);
    chk("multi_early_btn", Btn, 8'h00);
    tick(1);
    chk("multi_btn", Btn, 8'hA5);
    chk("multi_rise", BtnRise, 8'hA5);
    chk("multi_tog", Toggle, 8'hA5);
    tick(1);
    chk("multi_rise_end", BtnRise, 8'h00);
    BtnRaw = 8'hA4;
    tick(6);
    chk("multi_b0rel_btn", Btn, 8'hA4);
    chk("multi_b0rel_fall", BtnFall, 8'h01);
    chk("multi_b0rel_rise", BtnRise, 8'h00);
    BtnRaw = 8'hA5;
    tick(6);
    chk("multi_b0re_btn", Btn, 8'hA5);
    chk("multi_b0re_rise", BtnRise, 8'h01);
    chk("multi_b0re_tog", Toggle, 8'hA4);
    BtnRaw = 8'h00;
    tick(8);
    chk("multi_rel_btn", Btn, 8'h00);
    chk("multi_rel_tog", Toggle, 8'hA4);

    // Reset mid-count on bit 2, input held high through reset
    BtnRaw = 8'h04;
    tick(4);
    chk("midcnt_pre_btn", Btn, 8'h00);
    Rst_n = 1'b0;
    #2;
    chk("midcnt_rst_tog", Toggle, 8'h00);
    tick(1);
    Rst_n = 1'b1;
    tick(5);
    chk("midcnt_early_btn", Btn, 8'h00);
    chk("midcnt_early_rise", BtnRise, 8'h00);
    tick(1);
    chk("midcnt_btn", Btn, 8'h04);
    chk("midcnt_rise", BtnRise, 8'h04);
    chk("midcnt_tog", Toggle, 8'h04);
    for (int c = 0; c < 6; c++) begin
      tick(1);
      chk("midcnt_single_rise", BtnRise, 8'h00);
      chk("midcnt_hold_btn", Btn, 8'h04);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
